// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: width limit and a reference
// sum function that benches and wider adders can reuse.
package arith_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // {co, s} = a + b + ci at FA_MAX_WIDTH+1 bits; narrower callers zero-extend
  // their operands and take the low WIDTH+1 bits of the result.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    ci
  );
    return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, ci};
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; the producer drives the master side.
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (
    output in_valid, a, b, ci,
    input  out_valid, s, co
  );

  modport slave (
    input  in_valid, a, b, ci,
    output out_valid, s, co
  );
endinterface

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder; one link of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {co, s} <= a + b + ci one clock after an
// accepted input; s/co hold while in_valid is low.
module full_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic        clk,
  input logic        rst_n,
  full_adder_if.slave bus
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = bus.ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s         <= '0;
      bus.co        <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.s  <= sum;
        bus.co <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH 1, 8 and 32.
module tb_full_adder;
  import arith_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  full_adder_if #(.WIDTH(1))  w1_if  ();
  full_adder_if #(.WIDTH(8))  w8_if  ();
  full_adder_if #(.WIDTH(32)) w32_if ();

  full_adder #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(w1_if));
  full_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(w8_if));
  full_adder #(.WIDTH(32)) u_w32 (.clk(clk), .rst_n(rst_n), .bus(w32_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({w1_if.out_valid, w1_if.co, w1_if.s} !== 3'b000)
      $display("FAIL reset_w1: got %b want 000", {w1_if.out_valid, w1_if.co, w1_if.s});
    else n_pass++;
    n_total++;
    if ({w8_if.out_valid, w8_if.co, w8_if.s} !== 10'h000)
      $display("FAIL reset_w8: got %h want 000", {w8_if.out_valid, w8_if.co, w8_if.s});
    else n_pass++;
    // Reset must win over a valid input at the edge.
    w8_if.in_valid = 1'b1; w8_if.a = 8'hFF; w8_if.b = 8'hFF; w8_if.ci = 1'b1;
    tick();
    n_total++;
    if ({w8_if.out_valid, w8_if.co, w8_if.s} !== 10'h000)
      $display("FAIL reset_wins: got %h want 000", {w8_if.out_valid, w8_if.co, w8_if.s});
    else n_pass++;
    w8_if.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] tt [8];
    logic [2:0] v;
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      w1_if.in_valid = 1'b1;
      {w1_if.a, w1_if.b, w1_if.ci} = v;
      tick();
      n_total++;
      if ({w1_if.out_valid, w1_if.co, w1_if.s} !== {1'b1, tt[i]})
        $display("FAIL w1_abc_%b: got v/co/s=%b want %b", v,
                 {w1_if.out_valid, w1_if.co, w1_if.s}, {1'b1, tt[i]});
      else n_pass++;
    end
    w1_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap_w8();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vc [3];
    logic [8:0] want [3];
    va = '{8'hFF, 8'h80, 8'h12};
    vb = '{8'h00, 8'h80, 8'h34};
    vc = '{1'b1,  1'b0,  1'b1};
    want = '{9'h100, 9'h100, 9'h047};
    for (int i = 0; i < 3; i++) begin
      w8_if.in_valid = 1'b1;
      w8_if.a = va[i]; w8_if.b = vb[i]; w8_if.ci = vc[i];
      tick();
      n_total++;
      if ({w8_if.out_valid, w8_if.co, w8_if.s} !== {1'b1, want[i]})
        $display("FAIL w8_wrap_%0d: got v/co/s=%h want %h", i,
                 {w8_if.out_valid, w8_if.co, w8_if.s}, {1'b1, want[i]});
      else n_pass++;
    end
    w8_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    w1_if.in_valid = 1'b1;
    w1_if.a = 1'b1; w1_if.b = 1'b1; w1_if.ci = 1'b1;
    tick();
    n_total++;
    if ({w1_if.out_valid, w1_if.co, w1_if.s} !== 3'b111)
      $display("FAIL hold_accept: got %b want 111", {w1_if.out_valid, w1_if.co, w1_if.s});
    else n_pass++;
    w1_if.in_valid = 1'b0;
    w1_if.a = 1'b0; w1_if.b = 1'b0; w1_if.ci = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({w1_if.out_valid, w1_if.co, w1_if.s} !== 3'b011)
        $display("FAIL hold_cycle_%0d: got %b want 011", i,
                 {w1_if.out_valid, w1_if.co, w1_if.s});
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    w8_if.in_valid = 1'b1;
    w8_if.a = 8'h01; w8_if.b = 8'h01; w8_if.ci = 1'b0;
    tick();
    n_total++;
    if ({w8_if.out_valid, w8_if.co, w8_if.s} !== 10'h202)
      $display("FAIL areset_pre: got %h want 202", {w8_if.out_valid, w8_if.co, w8_if.s});
    else n_pass++;
    w8_if.a = 8'h10; w8_if.b = 8'h20; w8_if.ci = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({w8_if.out_valid, w8_if.co, w8_if.s} !== 10'h000)
      $display("FAIL areset_immediate: got %h want 000", {w8_if.out_valid, w8_if.co, w8_if.s});
    else n_pass++;
    tick();
    n_total++;
    if ({w8_if.out_valid, w8_if.co, w8_if.s} !== 10'h000)
      $display("FAIL areset_discard: got %h want 000", {w8_if.out_valid, w8_if.co, w8_if.s});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    w8_if.a = 8'h05; w8_if.b = 8'h06; w8_if.ci = 1'b1;
    tick();
    n_total++;
    if ({w8_if.out_valid, w8_if.co, w8_if.s} !== 10'h20C)
      $display("FAIL areset_first_after: got %h want 20c", {w8_if.out_valid, w8_if.co, w8_if.s});
    else n_pass++;
    w8_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_x_prop();
    w1_if.in_valid = 1'b1;
    w1_if.a = 1'bx; w1_if.b = 1'bx; w1_if.ci = 1'bx;
    tick();
    n_total++;
    if (w1_if.out_valid !== 1'b1)
      $display("FAIL x_out_valid: got %b want 1", w1_if.out_valid);
    else n_pass++;
    w1_if.a = 1'b0; w1_if.b = 1'b0; w1_if.ci = 1'b0;
    tick();
    n_total++;
    if ({w1_if.out_valid, w1_if.co, w1_if.s} !== 3'b100)
      $display("FAIL x_recover: got %b want 100", {w1_if.out_valid, w1_if.co, w1_if.s});
    else n_pass++;
    w1_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random_w32();
    logic [FA_MAX_WIDTH:0] r;
    logic [32:0]           exp_sum;
    logic                  exp_valid;
    logic [31:0]           ra;
    logic [31:0]           rb;
    logic                  rc;
    logic                  rv;
    int                    errs;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    exp_sum   = '0;
    exp_valid = 1'b0;
    errs      = 0;
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      rv = 1'($urandom_range(1));
      w32_if.in_valid = rv;
      w32_if.a = ra; w32_if.b = rb; w32_if.ci = rc;
      tick();
      if (rv) begin
        r = fa_ref({32'b0, ra}, {32'b0, rb}, rc);
        exp_sum = r[32:0];
      end
      exp_valid = rv;
      n_total++;
      if (w32_if.out_valid !== exp_valid) begin
        if (errs < 10)
          $display("FAIL rand_valid_%0d: got %b want %b", i, w32_if.out_valid, exp_valid);
        errs++;
      end else n_pass++;
      n_total++;
      if ({w32_if.co, w32_if.s} !== exp_sum) begin
        if (errs < 10)
          $display("FAIL rand_sum_%0d: got %h want %h", i, {w32_if.co, w32_if.s}, exp_sum);
        errs++;
      end else n_pass++;
    end
    w32_if.in_valid = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b1;
    w1_if.in_valid  = 1'b0; w1_if.a  = '0; w1_if.b  = '0; w1_if.ci  = 1'b0;
    w8_if.in_valid  = 1'b0; w8_if.a  = '0; w8_if.b  = '0; w8_if.ci  = 1'b0;
    w32_if.in_valid = 1'b0; w32_if.a = '0; w32_if.b = '0; w32_if.ci = 1'b0;

    test_reset();
    test_exhaustive_w1();
    test_wrap_w8();
    test_hold();
    test_async_reset();
    test_x_prop();
    test_random_w32();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
